alu_cmd_issuer: RTL
===================

// Module: alu_cmd_issuer
// PURPOSE
//  Upstream command stage for the 5-bit signed ALU. Buffers ALU commands in a FIFO
//  (valid/ready in) and issues them one at a time on the ALU control/operand pins.
//  Captures the ALU result c after a fixed latency and returns it on a valid/ready
//  result port. Exactly one command is in flight at a time.
// PARAMETERS
//  DEPTH    4  command FIFO entries (power of 2, >=2)
//  RES_LAT  1  cycles from the ALU_en cycle to c being valid (0..7)
// PORTS
//  clk        in   1  clock, all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  cmd_valid  in   1  command offered
//  cmd_ready  out  1  FIFO can accept (= !full)
//  cmd_a_en   in   1  command a_en
//  cmd_b_en   in   1  command b_en
//  cmd_a_op   in   3  command a_op
//  cmd_b_op   in   2  command b_op
//  cmd_A      in   5  signed operand A
//  cmd_B      in   5  signed operand B
//  ALU_en     out  1  ALU enable, 1-cycle pulse per command
//  a_en       out  1  to ALU
//  b_en       out  1  to ALU
//  a_op       out  3  to ALU
//  b_op       out  2  to ALU
//  A          out  5  signed, to ALU
//  B          out  5  signed, to ALU
//  c          in   6  signed ALU result
//  res_valid  out  1  result available
//  res_ready  in   1  result accepted
//  res_data   out  6  signed captured c
//  fifo_count out  $clog2(DEPTH+1)  entries currently in the FIFO
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO emptied, state IDLE. All outputs 0 except
//   cmd_ready=1. Any in-flight command and any pending result are discarded.
//   Reset mid-operation behaves identically.
//  FIFO
//   - Push on cmd_valid && cmd_ready.
//   - cmd_ready = (fifo_count != DEPTH); it does not depend on a same-cycle pop.
//   - No bypass: a command pushed in cycle P is first visible to the FSM in cycle P+1.
//   - Pop only on the IDLE->ISSUE transition. Push and pop in the same cycle are both honoured.
//  FSM: IDLE, ISSUE, WAIT, RESP
//   - IDLE: if fifo_count != 0, pop the head, register the operands/ops/enables onto
//     the ALU pins, go to ISSUE. Otherwise stay.
//   - ISSUE: ALU_en=1 for exactly this cycle (cycle I).
//     If RES_LAT=0: capture c at the end of this cycle and go to RESP.
//     Otherwise load cnt=RES_LAT-1 and go to WAIT.
//   - WAIT: ALU_en=0. If cnt==0: capture c into res_data and go to RESP.
//     Otherwise decrement cnt.
//   - RESP: res_valid=1 and res_data held stable. On res_ready, clear res_valid and
//     go to IDLE. There is no issue in the same cycle.
//  Operand/op/enable outputs hold their issued values from ISSUE until the next
//   issue. ALU_en is 0 in every state except ISSUE.
//  Timing:
//   - Push in cycle P with the FIFO empty and the FSM idle: ALU_en high in cycle P+2.
//   - c is sampled at the end of cycle I+RES_LAT. res_valid rises in cycle I+RES_LAT+1.
//   - Throughput: one command per RES_LAT+3 cycles when res_ready=1.
//  Widths: res_data = c verbatim (6-bit signed). No truncation or sign change.
//  res_valid low for any cycle with no pending result.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> cmd_ready=1, ALU_en=0, res_valid=0, fifo_count=0, A=B=0.
//  2 Single cmd, RES_LAT=1: push A=7, B=-3, a_en=1, a_op=0 in cycle P; model c=A+B
//    -> ALU_en=1 only in cycle P+2; res_valid=1 in cycle P+4 with res_data=6'sd4.
//  3 Fill, DEPTH=4, res_ready=0: push 6 back-to-back
//    -> 5 accepted (1 in flight + 4 queued); 6th sees cmd_ready=0 until a result
//       handshake and the next pop.
//  4 Backpressure: hold res_ready=0 for 10 cycles in RESP
//    -> res_valid and res_data stable; no ALU_en pulse.
//  5 Extremes: A=-16, B=-16, model c=-32 -> res_data=6'b100000. A=15, B=15, c=30 -> 6'b011110.
//  6 Reset in WAIT (RES_LAT=4) with 2 queued
//    -> next cycle fifo_count=0, res_valid=0, and the discarded result never appears.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus single-outstanding issue FSM in front of the 5-bit signed ALU.
// Each command is issued with a one-cycle ALU_en pulse; c is captured RES_LAT cycles later.
module alu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int RES_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_a_en,
  input  logic                         cmd_b_en,
  input  logic [2:0]                   cmd_a_op,
  input  logic [1:0]                   cmd_b_op,
  input  logic signed [4:0]            cmd_A,
  input  logic signed [4:0]            cmd_B,
  output logic                         ALU_en,
  output logic                         a_en,
  output logic                         b_en,
  output logic [2:0]                   a_op,
  output logic [1:0]                   b_op,
  output logic signed [4:0]            A,
  output logic signed [4:0]            B,
  input  logic signed [5:0]            c,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [5:0]            res_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 17;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [2:0] LAT_LOAD = (RES_LAT > 0) ? 3'(RES_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    cnt, cnt_next;
  logic          push, pop, capture;

  assign cmd_ready  = (count != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign ALU_en     = (state == ISSUE);
  assign res_valid  = (state == RESP);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op, cmd_A, cmd_B};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Zero latency captures c in the ALU_en cycle itself and skips WAIT entirely.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE:  if (pop) state_next = ISSUE;
      ISSUE: begin
        if (RES_LAT == 0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next   = LAT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      res_data <= '0;
      a_en     <= 1'b0;
      b_en     <= 1'b0;
      a_op     <= '0;
      b_op     <= '0;
      A        <= '0;
      B        <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) res_data <= c;
      if (pop) {a_en, b_en, a_op, b_op, A, B} <= head;
    end
  end

endmodule
